// File: rtl/div_ctrl.sv
// Iterative 32-bit restoring divider controller driving a shared external subtractor.
// Optional macro DIV_CTRL_ZERO_FAST_EN: a zero divisor short-circuits IDLE -> DONE.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] sub_a_o,
  output logic [WIDTH-1:0] sub_b_o,
  input  logic [WIDTH-1:0] sub_out_i,
  input  logic             sub_co_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;   // signed op with negative dividend
  logic             neg_b_q, neg_b_d;   // signed op with negative divisor
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude, shifted into the quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [4:0]       cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH:0]   part;
  logic             q_bit;
  logic             neg_res;
  logic [WIDTH-1:0] fix_val;

  assign accept  = start_i && !flush_i;
  assign part    = {rem_q, dvd_q[WIDTH-1]};
  assign q_bit   = part[WIDTH] || sub_co_i;
  assign neg_res = op_q[0] ? neg_a_q : (neg_a_q ^ neg_b_q);
  assign fix_val = op_q[0] ? rem_q : dvd_q;

  // NOTE: async reset clears every register, so no output depends on power-up values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIV_CTRL_ZERO_FAST_EN
          state_d = (src1_i == '0) ? DONE : ABS_A;
`else
          state_d = ABS_A;
`endif
        end
      end
      ABS_A:   state_d = ABS_B;
      ABS_B:   state_d = ITER;
      ITER:    state_d = (cnt_q == 5'd0) ? FIX : ITER;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    sub_a_o = '0;
    sub_b_o = '0;
    unique case (state_q)
      ABS_A:   sub_b_o = dvd_q;
      ABS_B:   sub_b_o = dvs_q;
      ITER: begin
        sub_a_o = part[WIDTH-1:0];
        sub_b_o = dvs_q;
      end
      FIX:     sub_b_o = fix_val;
      default: ;
    endcase
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    res_o  = res_q;
  end

  always_comb begin
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op_i;
          neg_a_d = !op_i[1] && src0_i[WIDTH-1];
          neg_b_d = !op_i[1] && src1_i[WIDTH-1];
          dvd_d   = src0_i;
          dvs_d   = src1_i;
          rem_d   = '0;
          cnt_d   = '0;
`ifdef DIV_CTRL_ZERO_FAST_EN
          if (src1_i == '0) begin
            if (op_i[0])                          res_d = src0_i;
            else if (!op_i[1] && src0_i[WIDTH-1]) res_d = {{(WIDTH-1){1'b0}}, 1'b1};
            else                                  res_d = '1;
          end
`endif
        end
      end
      ABS_A: if (neg_a_q) dvd_d = sub_out_i;
      ABS_B: begin
        if (neg_b_q) dvs_d = sub_out_i;
        cnt_d = 5'd31;
      end
      ITER: begin
        rem_d = q_bit ? sub_out_i : part[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      end
      FIX: if (!flush_i) res_d = neg_res ? sub_out_i : fix_val;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized ops checked
// against an arithmetic reference model; models the shared external subtractor.
module tb_div_ctrl;

`ifdef DIV_CTRL_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush, sub_co, busy, done;
  logic [1:0]  op;
  logic [31:0] src0, src1, sub_a, sub_b, sub_out, res;
  logic [31:0] last_res;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign sub_out = sub_a - sub_b;
  assign sub_co  = (sub_a >= sub_b);

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .src0_i(src0), .src1_i(src1),
    .flush_i(flush), .sub_a_o(sub_a), .sub_b_o(sub_b), .sub_out_i(sub_out),
    .sub_co_i(sub_co), .busy_o(busy), .done_o(done), .res_o(res)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               sgn, is_mod;
    sa = a; sb = b; sgn = !o[1]; is_mod = o[0];
    if (b == 32'd0) begin
      if (is_mod)         return a;
      if (sgn && a[31])   return 32'd1;
      return 32'hFFFF_FFFF;
    end
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_mod ? 32'd0 : 32'h8000_0000;
    if (sgn) return is_mod ? sa % sb : sa / sb;
    return is_mod ? a % b : a / b;
  endfunction

  // Issue one op; optionally pulse start again mid-operation (must be ignored).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    logic [31:0] exp;
    int          n, want;
    exp  = ref_res(o, a, b);
    want = (FAST && b == 32'd0) ? 1 : 36;
    @(negedge clk);
    start = 1'b1; op = o; src0 = a; src1 = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); src0 = $urandom; src1 = $urandom;
    n = 1;
    check("busy_cycle1", 32'(busy), 32'd1);
    while (!done && n < 100) begin
      start = (poke && n == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, want);
    check($sformatf("res op%0d %h/%h", o, a, b), res, exp);
    check("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("res_hold", res, exp);
    last_res = exp;
  endtask

  task automatic flush_at(input int cyc, input logic [31:0] a, input logic [31:0] b);
    int dones;
    @(negedge clk);
    start = 1'b1; op = 2'b10; src0 = a; src1 = b;
    @(negedge clk);
    start = 1'b0;
    repeat (cyc - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check($sformatf("flush%0d_busy", cyc), 32'(busy), 32'd0);
    check($sformatf("flush%0d_done", cyc), 32'(done), 32'd0);
    check($sformatf("flush%0d_res", cyc), res, last_res);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check($sformatf("flush%0d_no_done", cyc), dones, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src0 = '0; src1 = '0;
    last_res = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_sub_a", sub_a, 32'd0);
    check("rst_sub_b", sub_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b10, 32'd100, 32'd7, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op(2'b11, 32'd9, 32'd0, 1'b0);
    run_op(2'b10, 32'd12345, 32'd0, 1'b0);
    run_op(2'b00, 32'd12345, 32'd0, 1'b0);
    run_op(2'b11, 32'hDEAD_BEEF, 32'd255, 1'b1);

    // Flush in ITER, then a new op right away; flush in FIX must leave res alone.
    flush_at(20, 32'd1000, 32'd3);
    run_op(2'b00, 32'hFFFF_FC18, 32'd7, 1'b0);
    flush_at(35, 32'd77, 32'd5);

    // Flush together with start in IDLE: start is not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b10; src0 = 32'd50; src1 = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", 32'(busy), 32'd0);

    // Async reset mid-ITER, between clock edges.
    @(negedge clk);
    start = 1'b1; op = 2'b10; src0 = 32'hFFFF_0000; src1 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_res", res, 32'd0);
    check("arst_sub_a", sub_a, 32'd0);
    check("arst_sub_b", sub_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    run_op(2'b10, 32'd81, 32'd9, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF;
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(o, a, b, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be 32 (only supported value, matches the shared 32-bit adder/subtractor).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU.
REQ-006 src0 / src1  input  32 each  dividend / divisor, captured on accepted start.
REQ-007 flush  input  1  pipeline flush; aborts any operation.
REQ-008 sub_a / sub_b  output  32 each  operands to the shared subtractor (sub_out = sub_a - sub_b).
REQ-009 sub_out  input  32  subtractor difference.
REQ-010 sub_co  input  1  subtractor carry; 1 means sub_a >= sub_b unsigned.
REQ-011 busy  output  1  high in every state except IDLE; the pipeline SHALL route the subtractor to this block while busy.
REQ-012 done  output  1  one-cycle result-valid pulse.
REQ-013 res  output  32  quotient (DIV) or remainder (MOD).

Function
REQ-014 States SHALL be IDLE, ABS_A, ABS_B, ITER, FIX, DONE.
REQ-015 IDLE -> ABS_A on start && !flush; operands and op captured on that edge; start in any other state ignored.
REQ-016 ABS_A: signed op with src0[31]=1 -> sub_a=0, sub_b=dividend, magnitude <= sub_out; otherwise magnitude unchanged. ABS_B: same for divisor. One cycle each.
REQ-017 ITER SHALL run exactly 32 cycles (5-bit counter, 31 down to 0), one quotient bit per cycle, MSB first.
REQ-018 Per ITER cycle: 33-bit partial remainder P = {R,next dividend bit}; sub_a = P[31:0], sub_b = |divisor|; if P[32] or sub_co, R <= sub_out and quotient bit = 1, else R <= P[31:0] and bit = 0.
REQ-019 FIX: quotient negated (0 - q via subtractor) when signed and sign(src0) != sign(src1); remainder negated when signed and src0[31]=1; only the result selected by op is fixed and latched into res.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; res SHALL hold until the next accepted start's FIX.
REQ-021 Latency: start sampled at edge 0 -> done high in cycle 36 (ABS_A 1, ABS_B 2, ITER 3..34, FIX 35, DONE 36); busy high cycles 1..36.
REQ-022 flush in any state: next state IDLE, no done pulse, res unchanged; flush with start in IDLE: start not accepted.
REQ-023 Outside ABS_A/ABS_B/ITER/FIX, sub_a and sub_b SHALL be 0.
REQ-024 Divide by zero: DIV.WU -> 32'hFFFF_FFFF; DIV.W -> 32'hFFFF_FFFF if src0>=0, 32'h0000_0001 if src0<0; MOD.* -> src0.
REQ-025 Overflow DIV.W 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; MOD.W same operands -> 0.

Reset
REQ-026 rst SHALL force IDLE, busy=0, done=0, res=0, counter=0, sub_a=sub_b=0 immediately, regardless of clk, including mid-ITER.
REQ-027 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-028 Macro DIV_CTRL_ZERO_FAST_EN defined: src1==0 at accepted start -> IDLE goes directly to DONE, done high in cycle 1, res per REQ-024.
REQ-029 Macro undefined: divide by zero runs the full 36-cycle sequence and yields identical REQ-024 values.

Verification
REQ-030 DIV.WU 100/7 -> done at cycle 36, res=14; MOD.WU 100/7 -> res=2.
REQ-031 DIV.W -7/2 -> res=32'hFFFF_FFFD; MOD.W -7/2 -> res=32'hFFFF_FFFF; DIV.W 32'h8000_0000/-1 -> 32'h8000_0000.
REQ-032 DIV.W -5/0 -> res=1; MOD.WU 9/0 -> res=9; done at cycle 1 with DIV_CTRL_ZERO_FAST_EN, cycle 36 without.
REQ-033 flush at cycle 20 -> busy low next cycle, no done, res keeps prior value; new start next cycle completes correctly.
REQ-034 rst at cycle 10 between edges -> busy, done, res, sub_a, sub_b 0 at once; start pulsed during busy ignored (single done only).
